// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master, 4 CKP/CPH modes, SCK divider, NUM_CS selects.
// Ports: clk, reset (sync, high); start_stb/tx_data/cs_sel/CKP/CPH latched on start;
// MISO in; MOSI/SCK/CS serial side; rx_data, busy, done status.
// Option macro SPI_LSB_FIRST_EN adds input lsb_first (1 = LSB first).
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 2,
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_stb,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CSW-1:0]        cs_sel,
  input  logic                  CKP,
  input  logic                  CPH,
`ifdef SPI_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCK,
  output logic [NUM_CS-1:0]     CS,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CW  = $clog2(CLK_DIV) + 1;
  localparam int HPW = $clog2(2 * DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [HPW-1:0]        hp_q, hp_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, rx_sr_q, rx_q;
  logic [NUM_CS-1:0]     cs_q, cs_dec;
  logic                  mosi_q, sck_q;
  logic                  cph_q, lsb_q, lsb_in;
  logic                  last, accept, tick;
  logic                  lead, smp, drv;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic first_bit(
    input logic [DATA_WIDTH-1:0] w,
    input logic                  lsb
  );
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(
    input logic [DATA_WIDTH-1:0] w,
    input logic                  lsb
  );
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Out-of-range selects match no line, so CS stays all high.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
    end
  end

  assign last = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    accept  = 1'b0;
    tick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_stb) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          hp_d    = '0;
          tick    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          if (hp_q == HPW'(2 * DATA_WIDTH - 1)) begin
            state_d = HOLD;
          end else begin
            hp_d = hp_q + 1'b1;
            tick = 1'b1;
          end
        end
      end
      HOLD: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Toggle into an even half-period index is a leading edge.
  assign lead = (state_q == SETUP) | hp_q[0];
  assign smp  = tick & (lead ^ cph_q);
  assign drv  = tick & ~(lead ^ cph_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      rx_q    <= '0;
      cs_q    <= '1;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      cph_q   <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      if (state_q == IDLE) sck_q <= CKP;
      if (tick) sck_q <= ~sck_q;
      if (accept) begin
        cph_q <= CPH;
        lsb_q <= lsb_in;
        cs_q  <= cs_dec;
        // CPH=0 presents the first bit during SETUP.
        if (CPH) begin
          tx_sr_q <= tx_data;
        end else begin
          tx_sr_q <= shift_out(tx_data, lsb_in);
          mosi_q  <= first_bit(tx_data, lsb_in);
        end
      end
      if (drv) begin
        mosi_q  <= first_bit(tx_sr_q, lsb_q);
        tx_sr_q <= shift_out(tx_sr_q, lsb_q);
      end
      if (smp) begin
        rx_sr_q <= lsb_q ? {MISO, rx_sr_q[DATA_WIDTH-1:1]}
                         : {rx_sr_q[DATA_WIDTH-2:0], MISO};
      end
      if (state_q == HOLD && state_d == DONE) begin
        cs_q <= '1;
        rx_q <= rx_sr_q;
      end
    end
  end

  assign MOSI    = mosi_q;
  assign SCK     = sck_q;
  assign CS      = cs_q;
  assign rx_data = rx_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: scoreboard bench for spi_master_multi.
// Second instance with NUM_CS=3 covers an out-of-range chip select.
`timescale 1ns/1ps
module tb_spi_master_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_stb, CKP, CPH;
  logic       MISO, MOSI, SCK, busy, done;
  logic [7:0] tx_data, rx_data;
  logic [0:0] cs_sel;
  logic [1:0] CS;
`ifdef SPI_LSB_FIRST_EN
  logic       lsb_first;
`endif

  logic       start3, MOSI3, SCK3, busy3, done3;
  logic [1:0] cs_sel3;
  logic [2:0] CS3;
  logic [7:0] rx3;

  spi_master_multi #(
    .DATA_WIDTH(8), .CLK_DIV(2), .NUM_CS(2)
  ) u_dut (
    .clk(clk), .reset(reset), .start_stb(start_stb),
    .tx_data(tx_data), .cs_sel(cs_sel),
    .CKP(CKP), .CPH(CPH),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .CS(CS),
    .rx_data(rx_data), .busy(busy), .done(done)
  );

  spi_master_multi #(
    .DATA_WIDTH(8), .CLK_DIV(2), .NUM_CS(3)
  ) u_dut3 (
    .clk(clk), .reset(reset), .start_stb(start3),
    .tx_data(tx_data), .cs_sel(cs_sel3),
    .CKP(CKP), .CPH(CPH),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .MISO(MOSI3), .MOSI(MOSI3), .SCK(SCK3), .CS(CS3),
    .rx_data(rx3), .busy(busy3), .done(done3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] rx;
    logic [1:0] cs;
    logic [7:0] sl;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];

  // test-side view of the mode and the slave model
  logic       ckp_t = 1'b0, cph_t = 1'b0, lb = 1'b1;
  logic [7:0] slave_word = 8'h00;
  logic       miso_s = 1'b0;
  assign MISO = lb ? MOSI : miso_s;

  logic       prev_busy = 1'b0, prev_sck = 1'b0;
  int         edges = 0, bcnt = 0;
  logic [7:0] sl_rx = 8'h00, sl_tx = 8'h00;
  logic [1:0] cs_cap = 2'b11;
  exp_t       e;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      edges  = 0;
      bcnt   = 0;
      sl_rx  = 8'h00;
      sl_tx  = slave_word;
      cs_cap = CS;
    end
    if (busy) begin
      bcnt++;
      if (SCK !== prev_sck) begin
        edges++;
        if ((prev_sck == ckp_t) ^ cph_t) begin
          sl_rx = {sl_rx[6:0], MOSI};
        end else if (cph_t) begin
          miso_s = sl_tx[7];
          sl_tx  = sl_tx << 1;
        end
      end
    end
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.rx));
        chk("cs_active", 32'(cs_cap), 32'(e.cs));
        chk("sck_edges", 32'(edges), 32'd16);
        chk("slave_word", 32'(sl_rx), 32'(e.sl));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_cycles", 32'(bcnt), 32'd37);
      end
    end
    prev_busy = busy;
    prev_sck  = SCK;
  end

  logic cs3_low = 1'b0;
  exp_t e3;

  always @(negedge clk) begin
    if (busy3 && CS3 !== 3'b111) cs3_low = 1'b1;
    if (done3) begin
      if (q3.size() == 0) begin
        chk("unexpected_done3", 32'd1, 32'd0);
      end else begin
        e3 = q3.pop_front();
        chk("rx3", 32'(rx3), 32'(e3.rx));
        chk("done3_cycle", 32'(cyc), 32'(e3.cyc));
        chk("cs3_low_seen", 32'(cs3_low), 32'd0);
      end
    end
  end

  task automatic start_xfer(input logic [7:0] tx,
                            input logic [0:0] sel,
                            input logic       ckp,
                            input logic       cph,
                            input logic       push,
                            input logic [1:0] cs_exp,
                            input logic [7:0] rx_exp,
                            input logic [7:0] sl_exp,
                            output int        acc);
    exp_t x;
    @(negedge clk);
    CKP   = ckp;
    CPH   = cph;
    ckp_t = ckp;
    cph_t = cph;
    @(negedge clk);
    tx_data   = tx;
    cs_sel    = sel;
    start_stb = 1'b1;
    acc       = cyc + 1;
    x.rx  = rx_exp;
    x.cs  = cs_exp;
    x.sl  = sl_exp;
    x.cyc = acc + 36;
    if (push) q.push_back(x);
    @(negedge clk);
    start_stb = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  int   acc;
  exp_t x3;

  initial begin
    reset     = 1'b1;
    start_stb = 1'b0;
    tx_data   = 8'h00;
    cs_sel    = 1'b0;
    CKP       = 1'b0;
    CPH       = 1'b0;
    start3    = 1'b0;
    cs_sel3   = 2'd0;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(CS), 32'h3);
    chk("rst_sck", 32'(SCK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    reset = 1'b0;

    // mode 0 loopback
    start_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1,
               2'b10, 8'hA5, 8'hA5, acc);
    drain("t1_drain");

    // mode 3 with slave returning 3C
    @(negedge clk);
    lb         = 1'b0;
    slave_word = 8'h3C;
    CKP        = 1'b1;
    ckp_t      = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_sck_idle", 32'(SCK), 32'd1);
    start_xfer(8'hC3, 1'b0, 1'b1, 1'b1, 1'b1,
               2'b10, 8'h3C, 8'hC3, acc);
    drain("t2_drain");

    // second start mid-transfer is ignored
    lb = 1'b1;
    start_xfer(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1,
               2'b01, 8'h5A, 8'h5A, acc);
    repeat (8) @(negedge clk);
    tx_data   = 8'hFF;
    cs_sel    = 1'b0;
    CKP       = 1'b1;
    CPH       = 1'b1;
    start_stb = 1'b1;
    @(negedge clk);
    start_stb = 1'b0;
    CKP       = 1'b0;
    CPH       = 1'b0;
    drain("t3_drain");
    repeat (45) @(negedge clk);

    // reset mid-transfer
    start_xfer(8'h96, 1'b0, 1'b0, 1'b0, 1'b0,
               2'b10, 8'h00, 8'h00, acc);
    repeat (14) @(negedge clk);
    chk("t4_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_cs", 32'(CS), 32'h3);
    chk("t4_sck", 32'(SCK), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_rx", 32'(rx_data), 32'd0);
    chk("t4_mosi", 32'(MOSI), 32'd0);
    // reset and start together: reset wins
    start_stb = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    start_stb = 1'b0;
    @(negedge clk);
    chk("t4_rst_start", 32'(busy), 32'd0);
    start_xfer(8'h96, 1'b0, 1'b0, 1'b0, 1'b1,
               2'b10, 8'h96, 8'h96, acc);
    drain("t4_drain");

    // bit order, loopback 01
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b1;
    start_xfer(8'h01, 1'b0, 1'b0, 1'b0, 1'b1,
               2'b10, 8'h01, 8'h80, acc);
`else
    start_xfer(8'h01, 1'b0, 1'b0, 1'b0, 1'b1,
               2'b10, 8'h01, 8'h01, acc);
`endif
    drain("t6_drain");

    // out-of-range select on the 3-CS instance
    @(negedge clk);
    cs3_low = 1'b0;
    tx_data = 8'h69;
    cs_sel3 = 2'd3;
    start3  = 1'b1;
    x3.rx   = 8'h69;
    x3.cs   = 2'b11;
    x3.sl   = 8'h00;
    x3.cyc  = cyc + 1 + 36;
    q3.push_back(x3);
    @(negedge clk);
    start3 = 1'b0;
    for (int n = 0; n < 200 && q3.size() != 0; n++) begin
      @(negedge clk);
    end
    chk("t5_drain", 32'(q3.size()), 32'd0);
    chk("t5_sck3_idle", 32'(SCK3), 32'd0);
    chk("t5_busy3", 32'(busy3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
